// File: rtl/led_seq_pkg.sv
// Shared constants for the LED colour sequencer.
// Encodings for the per-channel mode and direction inputs.
package led_seq_pkg;
  localparam logic MODE_WRAP   = 1'b0;
  localparam logic MODE_BOUNCE = 1'b1;
  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
endpackage

// File: rtl/led_seq_channel.sv
// One sequencer channel: colour register, bounce heading and endpoint pulse.
// Steps through FIRST..LAST on each tick while button is held.
module led_seq_channel
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int FIRST = 1,
  parameter int LAST  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             button,
  input  logic             dir,
  input  logic             mode,
  input  logic             clr,
  output logic [WIDTH-1:0] colour,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] LO  = WIDTH'(FIRST);
  localparam logic [WIDTH-1:0] HI  = WIDTH'(LAST);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  // Turnaround targets; a single-code range never leaves its endpoint.
  localparam logic [WIDTH-1:0] HI_TURN =
    (FIRST == LAST) ? WIDTH'(LAST) : WIDTH'(LAST - 1);
  localparam logic [WIDTH-1:0] LO_TURN =
    (FIRST == LAST) ? WIDTH'(FIRST) : WIDTH'(FIRST + 1);

  logic [WIDTH-1:0] colour_d;
  logic             heading, heading_d;
  logic             pulse_d;
  logic             advance, in_range, at_hi, at_lo;
  logic             load, step_wrap, step_bounce;

  assign advance     = tick & button & ~clr;
  assign in_range    = (colour >= LO) && (colour <= HI);
  assign at_hi       = (colour == HI);
  assign at_lo       = (colour == LO);
  assign load        = advance & ~in_range;
  assign step_wrap   = advance & in_range & (mode == MODE_WRAP);
  assign step_bounce = advance & in_range & (mode == MODE_BOUNCE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colour     <= '0;
      heading    <= DIR_UP;
      wrap_pulse <= 1'b0;
    end else begin
      colour     <= colour_d;
      heading    <= heading_d;
      wrap_pulse <= pulse_d;
    end
  end

  always_comb begin
    colour_d  = colour;
    heading_d = heading;
    pulse_d   = 1'b0;
    unique case (1'b1)
      clr: begin
        colour_d  = '0;
        heading_d = DIR_UP;
      end
      load: begin
        colour_d  = (dir == DIR_DOWN) ? HI : LO;
        heading_d = dir;
      end
      step_wrap: begin
        if (dir == DIR_UP) begin
          colour_d = at_hi ? LO : colour + ONE;
          pulse_d  = at_hi;
        end else begin
          colour_d = at_lo ? HI : colour - ONE;
          pulse_d  = at_lo;
        end
      end
      step_bounce: begin
        if (heading == DIR_UP) begin
          if (at_hi) begin
            colour_d  = HI_TURN;
            heading_d = DIR_DOWN;
            pulse_d   = 1'b1;
          end else begin
            colour_d = colour + ONE;
          end
        end else begin
          if (at_lo) begin
            colour_d  = LO_TURN;
            heading_d = DIR_UP;
            pulse_d   = 1'b1;
          end else begin
            colour_d = colour - ONE;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/led_sequencer.sv
// Multi-channel LED colour sequencer: shared prescaler feeding
// CHANNELS independent colour stepping channels.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 3,
  parameter int DIVIDE   = 4,
  parameter int FIRST    = 1,
  parameter int LAST     = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       button,
  input  logic [CHANNELS-1:0]       dir,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] colour,
  output logic [CHANNELS-1:0]       wrap_pulse,
  output logic                      tick
);

  localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [CW-1:0] TOP = CW'(DIVIDE - 1);

  logic [CW-1:0] count;

  // Tick is registered so it reads low in reset even when DIVIDE is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (count == TOP);
      count <= (count == TOP) ? '0 : count + CW'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_seq_channel #(
      .WIDTH (WIDTH),
      .FIRST (FIRST),
      .LAST  (LAST)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .button     (button[i]),
      .dir        (dir[i]),
      .mode       (mode[i]),
      .clr        (clr[i]),
      .colour     (colour[i*WIDTH +: WIDTH]),
      .wrap_pulse (wrap_pulse[i])
    );
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: default build plus a
// DIVIDE=1, FIRST=LAST=3 single-channel build.
module tb_led_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] button = '0;
  logic [1:0] dir    = '0;
  logic [1:0] mode   = '0;
  logic [1:0] clr    = '0;
  logic [5:0] colour;
  logic [1:0] wrap_pulse;
  logic       tick;

  logic       b2 = 1'b0;
  logic       d2 = 1'b0;
  logic       m2 = 1'b0;
  logic       c2 = 1'b0;
  logic [2:0] colour2;
  logic       wp2;
  logic       tick2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  led_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .dir        (dir),
    .mode       (mode),
    .clr        (clr),
    .colour     (colour),
    .wrap_pulse (wrap_pulse),
    .tick       (tick)
  );

  led_sequencer #(
    .CHANNELS (1),
    .WIDTH    (3),
    .DIVIDE   (1),
    .FIRST    (3),
    .LAST     (3)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (b2),
    .dir        (d2),
    .mode       (m2),
    .clr        (c2),
    .colour     (colour2),
    .wrap_pulse (wp2),
    .tick       (tick2)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, set inputs, release; returns with tick visible, colour still 0.
  task automatic restart(input logic [1:0] b, input logic [1:0] d,
                         input logic [1:0] m);
    @(negedge clk);
    rst_n  = 1'b0;
    button = b;
    dir    = d;
    mode   = m;
    clr    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_reset;
    #3;
    n_cmp++;
    if (colour !== 6'd0 || tick !== 1'b0 || wrap_pulse !== 2'b00) begin
      n_err++;
      $display("FAIL reset: colour=%h tick=%b wp=%b required 00/0/00",
               colour, tick, wrap_pulse);
    end
    button = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_cmp++;
      if (tick !== (k == 4)) begin
        n_err++;
        $display("FAIL tick_start[%0d]: tick=%b required %b", k, tick, k == 4);
      end
    end
    step(1);
    n_cmp++;
    if (colour[2:0] !== 3'd1 || tick !== 1'b0) begin
      n_err++;
      $display("FAIL first_load: colour0=%0d tick=%b required 1/0",
               colour[2:0], tick);
    end
  endtask

  task automatic test_wrap_up;
    int ec[7] = '{1, 2, 3, 4, 5, 6, 1};
    restart(2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        for (int k = 0; k < 3; k++) begin
          step(1);
          n_cmp++;
          if (colour[2:0] !== 3'(ec[i-1]) || wrap_pulse[0] !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_up_hold[%0d.%0d]: colour0=%0d wp0=%b required %0d/0",
                     i, k, colour[2:0], wrap_pulse[0], ec[i-1]);
          end
        end
      end
      step(1);
      n_cmp++;
      if (colour[2:0] !== 3'(ec[i]) || wrap_pulse[0] !== (i == 6) ||
          colour[5:3] !== 3'd0) begin
        n_err++;
        $display("FAIL wrap_up[%0d]: colour0=%0d wp0=%b colour1=%0d required %0d/%b/0",
                 i, colour[2:0], wrap_pulse[0], colour[5:3], ec[i], i == 6);
      end
    end
  endtask

  task automatic test_wrap_down;
    int ec[7] = '{6, 5, 4, 3, 2, 1, 6};
    restart(2'b01, 2'b01, 2'b00);
    for (int i = 0; i < 7; i++) begin
      step(1);
      n_cmp++;
      if (colour[2:0] !== 3'(ec[i]) || wrap_pulse[0] !== (i == 6)) begin
        n_err++;
        $display("FAIL wrap_down[%0d]: colour0=%0d wp0=%b required %0d/%b",
                 i, colour[2:0], wrap_pulse[0], ec[i], i == 6);
      end
      step(3);
    end
  endtask

  task automatic test_bounce;
    int ec[12] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 2};
    logic ew;
    restart(2'b01, 2'b00, 2'b01);
    for (int i = 0; i < 12; i++) begin
      ew = (i == 6) || (i == 11);
      step(1);
      n_cmp++;
      if (colour[2:0] !== 3'(ec[i]) || wrap_pulse[0] !== ew) begin
        n_err++;
        $display("FAIL bounce[%0d]: colour0=%0d wp0=%b required %0d/%b",
                 i, colour[2:0], wrap_pulse[0], ec[i], ew);
      end
      dir[0] = (i >= 3) && (i < 8);
      step(3);
    end
    dir = '0;
  endtask

  task automatic test_clear;
    restart(2'b11, 2'b00, 2'b00);
    for (int i = 1; i <= 4; i++) begin
      step(1);
      step(3);
    end
    n_cmp++;
    if (colour !== {3'd4, 3'd4} || tick !== 1'b1) begin
      n_err++;
      $display("FAIL clr_setup: colour=%h tick=%b required 24/1", colour, tick);
    end
    clr = 2'b01;
    step(1);
    clr = 2'b00;
    n_cmp++;
    if (colour[2:0] !== 3'd0 || colour[5:3] !== 3'd5 || wrap_pulse !== 2'b00) begin
      n_err++;
      $display("FAIL clr: colour0=%0d colour1=%0d wp=%b required 0/5/00",
               colour[2:0], colour[5:3], wrap_pulse);
    end
    step(4);
    n_cmp++;
    if (colour[2:0] !== 3'd1 || colour[5:3] !== 3'd6) begin
      n_err++;
      $display("FAIL clr_resume: colour0=%0d colour1=%0d required 1/6",
               colour[2:0], colour[5:3]);
    end
    step(2);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (colour !== 6'd0 || tick !== 1'b0 || wrap_pulse !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: colour=%h tick=%b wp=%b required 00/0/00",
               colour, tick, wrap_pulse);
    end
  endtask

  task automatic test_hold;
    restart(2'b01, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      step(3);
    end
    button = 2'b00;
    for (int k = 0; k < 20; k++) begin
      step(1);
      n_cmp++;
      if (colour[2:0] !== 3'd5 || wrap_pulse[0] !== 1'b0) begin
        n_err++;
        $display("FAIL hold[%0d]: colour0=%0d wp0=%b required 5/0",
                 k, colour[2:0], wrap_pulse[0]);
      end
    end
    button = 2'b01;
    step(1);
    n_cmp++;
    if (colour[2:0] !== 3'd6) begin
      n_err++;
      $display("FAIL hold_resume: colour0=%0d required 6", colour[2:0]);
    end
  endtask

  task automatic test_single;
    @(negedge clk);
    rst_n = 1'b0;
    b2 = 1'b1;
    m2 = 1'b0;
    #1;
    n_cmp++;
    if (tick2 !== 1'b0 || colour2 !== 3'd0) begin
      n_err++;
      $display("FAIL single_reset: tick=%b colour=%0d required 0/0",
               tick2, colour2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    n_cmp++;
    if (tick2 !== 1'b1 || colour2 !== 3'd0) begin
      n_err++;
      $display("FAIL single_tick: tick=%b colour=%0d required 1/0",
               tick2, colour2);
    end
    step(1);
    n_cmp++;
    if (colour2 !== 3'd3 || wp2 !== 1'b0) begin
      n_err++;
      $display("FAIL single_load: colour=%0d wp=%b required 3/0", colour2, wp2);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 4) m2 = 1'b1;
      step(1);
      n_cmp++;
      if (colour2 !== 3'd3 || wp2 !== 1'b1) begin
        n_err++;
        $display("FAIL single_run[%0d]: colour=%0d wp=%b required 3/1",
                 k, colour2, wp2);
      end
    end
    b2 = 1'b0;
    step(1);
    n_cmp++;
    if (colour2 !== 3'd3 || wp2 !== 1'b0) begin
      n_err++;
      $display("FAIL single_release: colour=%0d wp=%b required 3/0",
               colour2, wp2);
    end
  endtask

  initial begin
    test_reset;
    test_wrap_up;
    test_wrap_down;
    test_bounce;
    test_clear;
    test_hold;
    test_single;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised multi-channel LED colour sequencer: each channel steps its colour code through the range FIRST..LAST while its button is held, at a rate set by a shared prescaler. Generalises the single-channel, fixed 3-bit, every-clock light controller with per-channel direction, wrap or bounce mode, synchronous clear and endpoint pulses. Sits between debounced board buttons and the RGB LED drivers.

## Interface
- CHANNELS, 2, number of independent channels
- WIDTH, 3, colour code width in bits
- DIVIDE, 4, prescaler ratio; channels may advance once every DIVIDE clocks (DIVIDE ≥ 1)
- FIRST, 1, lowest legal colour code
- LAST, 6, highest legal colour code (FIRST ≤ LAST ≤ 2^WIDTH−1)
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- button  input  CHANNELS  per-channel advance enable, high = step on tick
- dir  input  CHANNELS  per-channel start direction, 0 = up, 1 = down
- mode  input  CHANNELS  per-channel mode, 0 = wrap, 1 = bounce
- clr  input  CHANNELS  per-channel synchronous clear to colour 0
- colour  output  CHANNELS*WIDTH  colour codes, channel i at bits [i*WIDTH +: WIDTH]
- wrap_pulse  output  CHANNELS  one-cycle pulse when a channel passes an endpoint
- tick  output  1  prescaler strobe, high one cycle in every DIVIDE

## Operation
- Reset (rst_n low): prescaler count 0, tick 0, every colour 0, every wrap_pulse 0, every heading register = up.
- Prescaler: free-running count 0..DIVIDE−1; tick high when count = DIVIDE−1, count then returns to 0. DIVIDE = 1: tick high every cycle after reset release.
- Per channel, priority per clock: clr > advance > hold.
- clr high: colour ← 0, heading ← up, wrap_pulse 0; ignores button and tick.
- Advance condition: tick & button & ~clr.
- Colour out of range (< FIRST or > LAST, including 0 after reset/clear): on advance, load FIRST if dir = 0, else LAST; heading ← dir; no wrap_pulse.
- Wrap mode, in range: up: LAST → FIRST with wrap_pulse, else +1; down: FIRST → LAST with wrap_pulse, else −1. Direction taken from dir input live each advance.
- Bounce mode, in range: move per heading register; at LAST heading up → LAST−1, heading ← down, wrap_pulse; at FIRST heading down → FIRST+1, heading ← up, wrap_pulse. dir ignored except when loading from out of range.
- FIRST = LAST: colour stays at FIRST; wrap_pulse on every in-range advance, both modes.
- Mode change mid-run: takes effect on next advance; bounce resumes from current heading register.
- Button released: colour holds indefinitely.
- Arithmetic in WIDTH bits; no overflow possible since LAST ≤ 2^WIDTH−1 and endpoints are checked before increment/decrement.

## Timing
- colour and wrap_pulse registered; update on the rising edge where tick = 1 is sampled together with button = 1.
- wrap_pulse high exactly the cycle after that edge, for one cycle.
- Minimum step interval DIVIDE clocks; first tick DIVIDE cycles after rst_n rises.
- clr effective on the next edge, one-cycle latency.
- rst_n assertion mid-sequence clears all state immediately (asynchronously); release is synchronised externally.
- Channels independent; simultaneous advances on all channels supported.

## Structure
- Package led_seq_pkg: MODE_WRAP = 0, MODE_BOUNCE = 1, DIR_UP = 0, DIR_DOWN = 1.
- Top led_sequencer: prescaler plus a generate loop of CHANNELS instances.
- Sub-module led_seq_channel: one channel's colour register, heading register and wrap_pulse logic; parameters WIDTH, FIRST, LAST; inputs tick, button, dir, mode, clr.

## Test plan
- Defaults, ch0 button = 1, dir = 0, mode = 0 from reset: colour0 sequence 0,1,2,3,4,5,6,1,… changing every 4 clocks; wrap_pulse0 on the 6→1 step; ch1 (button = 0) stays 0.
- ch0 dir = 1, mode = 0: sequence 0,6,5,4,3,2,1,6; wrap_pulse0 on 1→6 only.
- ch0 mode = 1, dir = 0: 1,2,…,6,5,4,…,1,2; wrap_pulse0 on 6→5 and 1→2; toggling dir mid-run has no effect.
- clr0 pulsed while colour0 = 4 and tick coincident: colour0 = 0 next cycle, then 1 on next advance; rst_n pulled low mid-run: all colours 0, tick 0 immediately.
- DIVIDE = 1, FIRST = LAST = 3: colour 0 → 3, then stays 3 with wrap_pulse every cycle while button held.
- Button released at colour 5 for 20 clocks: colour holds 5, no wrap_pulse; resumes 6 on first tick after re-press.
